// File: rtl/led_code_arbiter.sv
// led_code_arbiter
// Shares one active-low status LED between N_REQ requesters. A round-robin
// arbiter picks a requester, then an FSM plays its blink code: `code` pulses
// of P cycles lit, each followed by G cycles dark, then Q dark cycles of pause.
// Every output is registered and is derived from the next-state decision, so
// the outputs line up with the state they describe.
// Optional build macro: LED_CODE_ARB_HEARTBEAT_EN. When it is defined, the LED
// shows a heartbeat while idle (lit for the first P of every Q idle cycles).
module led_code_arbiter #(
  parameter int CLK_IN_HZ = 100000000,
  parameter int N_REQ     = 4,
  parameter int CODE_W    = 4,
  parameter int PULSE_MS  = 200,
  parameter int GAP_MS    = 200,
  parameter int PAUSE_MS  = 1000
) (
  input  logic                    clk_in,
  input  logic                    n_rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*CODE_W-1:0] code,
  output logic [N_REQ-1:0]        grant,
  output logic                    done,
  output logic                    busy,
  output logic                    led_out
);

  // Phase lengths in clock cycles
  localparam int P_CYC   = CLK_IN_HZ / 1000 * PULSE_MS;
  localparam int G_CYC   = CLK_IN_HZ / 1000 * GAP_MS;
  localparam int Q_CYC   = CLK_IN_HZ / 1000 * PAUSE_MS;
  localparam int PG_MAX  = (P_CYC > G_CYC) ? P_CYC : G_CYC;
  localparam int MAX_CYC = (PG_MAX > Q_CYC) ? PG_MAX : Q_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(N_REQ);

  // Terminal counts (count runs 0 .. len-1 inside a phase)
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P_CYC - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(G_CYC - 1);
  localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(Q_CYC - 1);
  localparam logic [CNT_W-1:0] P_LEN  = CNT_W'(P_CYC);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ON    = 3'd2,
    OFF   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                led_q, led_d;

  logic                pick_found_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [IDX_W-1:0]    pick_next_s;
  logic [CODE_W-1:0]   code_sel_s;
  int                  rr_j_s;

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign led_out = led_q;

  // The granted requester's code; only used in LOAD
  assign code_sel_s = code[idx_q*CODE_W +: CODE_W];

  // Round-robin search: first set req bit at or above the pointer, wrapping
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    pick_next_s  = '0;
    rr_j_s       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_j_s = int'(ptr_q) + k;
      if (rr_j_s >= N_REQ) begin
        rr_j_s = rr_j_s - N_REQ;
      end else begin
        rr_j_s = rr_j_s;
      end
      if (!pick_found_s && req[IDX_W'(rr_j_s)]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IDX_W'(rr_j_s);
        if (rr_j_s + 1 >= N_REQ) begin
          pick_next_s = '0;
        end else begin
          pick_next_s = IDX_W'(rr_j_s + 1);
        end
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state, phase counter and registered-output decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    rem_d   = rem_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;

    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = LOAD;
          idx_d   = pick_idx_s;
          ptr_d   = pick_next_s;
          grant_d = ONE_HOT0 << pick_idx_s;
        end else if (cnt_q >= Q_LAST) begin
          // Idle counter wraps every Q cycles to pace the heartbeat
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD: begin
        rem_d = code_sel_s;
        if (code_sel_s == '0) begin
          state_d = PAUSE;
        end else begin
          state_d = ON;
        end
      end
      ON: begin
        if (cnt_q == P_LAST) begin
          state_d = OFF;
        end else begin
          state_d = ON;
        end
      end
      OFF: begin
        if (cnt_q == G_LAST) begin
          rem_d = rem_q - CODE_W'(1);
          if (rem_q == CODE_W'(1)) begin
            state_d = PAUSE;
          end else begin
            state_d = ON;
          end
        end else begin
          state_d = OFF;
        end
      end
      PAUSE: begin
        if (cnt_q == Q_LAST) begin
          state_d = DONE;
        end else begin
          state_d = PAUSE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    // Every state entry restarts the phase counter so phase lengths are exact
    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_d;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

`ifdef LED_CODE_ARB_HEARTBEAT_EN
    if (state_d == IDLE) begin
      led_d = !(cnt_d < P_LEN);
    end else begin
      led_d = (state_d != ON);
    end
`else
    led_d = (state_d != ON);
`endif
  end

  // State and output registers; async reset returns everything to idle
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: tb/tb_led_code_arbiter.sv
// Directed self-checking bench for led_code_arbiter with P=8, G=8, Q=16.
// The heartbeat expectation follows LED_CODE_ARB_HEARTBEAT_EN.
module tb_led_code_arbiter;

  logic        clk_in;
  logic        n_rst;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  grant;
  logic        done;
  logic        busy;
  logic        led_out;

  int errors;
  int checks;

  logic [3:0] gr [0:255];
  logic       ld [0:255];
  logic       dn [0:255];
  logic       bz [0:255];

  led_code_arbiter #(
    .CLK_IN_HZ(4000),
    .N_REQ    (4),
    .CODE_W   (4),
    .PULSE_MS (2),
    .GAP_MS   (2),
    .PAUSE_MS (4)
  ) dut (
    .clk_in (clk_in),
    .n_rst  (n_rst),
    .req    (req),
    .code   (code),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .led_out(led_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Record n cycles of outputs at negedges; at cycle chg_at apply new req/code
  task automatic capture(input int n, input int chg_at,
                         input logic [3:0] req_new, input logic [15:0] code_new);
    for (int t = 0; t < n; t++) begin
      @(negedge clk_in);
      gr[t] = grant;
      ld[t] = led_out;
      dn[t] = done;
      bz[t] = busy;
      if (t == chg_at) begin
        req  = req_new;
        code = code_new;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    n_rst = 1'b0;
    req   = 4'b0000;
    @(negedge clk_in);
    n_rst = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    req   = 4'b0000;
    code  = 16'h0000;
    repeat (2) @(negedge clk_in);
    checks++;
    if (grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || led_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals: grant=%b done=%b busy=%b led=%b, required 0000 0 0 1",
               grant, done, busy, led_out);
    end
    n_rst = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_code3();
    int glen, ndone, bad;
    logic exp_led;
    req  = 4'b0001;
    code = 16'h0003;
    capture(72, 0, 4'b0000, 16'h0003);
    checks++;
    if (gr[0] !== 4'b0001 || bz[0] !== 1'b1) begin
      errors++;
      $display("FAIL code3_first: grant=%b busy=%b, required 0001 1", gr[0], bz[0]);
    end
    glen = 0;
    while (glen < 72 && gr[glen] === 4'b0001) glen++;
    checks++;
    if (glen != 66) begin
      errors++;
      $display("FAIL code3_glen: got %0d cycles, required 66", glen);
    end
    checks++;
    if (gr[66] !== 4'b0000 || bz[66] !== 1'b0) begin
      errors++;
      $display("FAIL code3_after: grant=%b busy=%b, required 0000 0", gr[66], bz[66]);
    end
    ndone = 0;
    for (int t = 0; t < 72; t++) if (dn[t] === 1'b1) ndone++;
    checks++;
    if (ndone != 1 || dn[65] !== 1'b1) begin
      errors++;
      $display("FAIL code3_done: count=%0d at65=%b, required 1 1", ndone, dn[65]);
    end
    bad = 0;
    for (int t = 0; t < 66; t++) begin
      exp_led = !((t >= 1 && t <= 8) || (t >= 17 && t <= 24) || (t >= 33 && t <= 40));
      if (ld[t] !== exp_led) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL code3_led: %0d wrong cycles, required 0", bad);
    end
  endtask

  task automatic test_code0();
    int glen, bad;
    wait_idle();
    req  = 4'b0001;
    code = 16'h0000;
    capture(24, 0, 4'b0000, 16'h0000);
    glen = 0;
    while (glen < 24 && gr[glen] === 4'b0001) glen++;
    checks++;
    if (glen != 18) begin
      errors++;
      $display("FAIL code0_glen: got %0d cycles, required 18", glen);
    end
    checks++;
    if (dn[17] !== 1'b1 || dn[16] !== 1'b0) begin
      errors++;
      $display("FAIL code0_done: at17=%b at16=%b, required 1 0", dn[17], dn[16]);
    end
    bad = 0;
    for (int t = 0; t < 18; t++) if (ld[t] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL code0_led: %0d lit cycles, required 0", bad);
    end
  endtask

  task automatic test_round_robin();
    int bad;
    logic [3:0] exp_g;
    do_reset();
    code = 16'h1111;
    req  = 4'b1111;
    capture(175, 174, 4'b0000, 16'h1111);
    bad = 0;
    for (int t = 0; t < 175; t++) begin
      exp_g = ((t % 35) < 34) ? (4'b0001 << ((t / 35) % 4)) : 4'b0000;
      if (gr[t] !== exp_g) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rr_order: %0d wrong cycles, required 0", bad);
    end
    checks++;
    if (gr[34] !== 4'b0000 || gr[35] !== 4'b0010) begin
      errors++;
      $display("FAIL rr_gap: g34=%b g35=%b, required 0000 0010", gr[34], gr[35]);
    end
    checks++;
    if (gr[140] !== 4'b0001 || gr[105] !== 4'b1000) begin
      errors++;
      $display("FAIL rr_wrap: g140=%b g105=%b, required 0001 1000", gr[140], gr[105]);
    end
  endtask

  task automatic test_drop_and_code_change();
    int glen, pulses;
    wait_idle();
    req  = 4'b0010;
    code = 16'h0020;
    capture(56, 3, 4'b0000, 16'h0070);
    glen = 0;
    while (glen < 56 && gr[glen] === 4'b0010) glen++;
    checks++;
    if (glen != 50) begin
      errors++;
      $display("FAIL drop_glen: got %0d cycles, required 50", glen);
    end
    checks++;
    if (dn[49] !== 1'b1) begin
      errors++;
      $display("FAIL drop_done: at49=%b, required 1", dn[49]);
    end
    pulses = 0;
    for (int t = 0; t < 56; t++) begin
      if (ld[t] === 1'b0 && (t == 0 || ld[t-1] === 1'b1) && gr[t] !== 4'b0000) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL drop_pulses: got %0d, required 2", pulses);
    end
  endtask

  task automatic test_async_reset();
    wait_idle();
    req  = 4'b0001;
    code = 16'h0003;
    repeat (4) @(negedge clk_in);
    checks++;
    if (led_out !== 1'b0 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL rst_pre: led=%b grant=%b, required 0 0001", led_out, grant);
    end
    req   = 4'b0000;
    n_rst = 1'b0;
    #1;
    checks++;
    if (led_out !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: led=%b grant=%b busy=%b done=%b, required 1 0000 0 0",
               led_out, grant, busy, done);
    end
    @(negedge clk_in);
    n_rst = 1'b1;
    req   = 4'b1001;
    @(negedge clk_in);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rst_ptr: grant=%b, required 0001", grant);
    end
    req = 4'b0000;
    wait_idle();
    req = 4'b1000;
    @(negedge clk_in);
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL rst_req3: grant=%b, required 1000", grant);
    end
    req = 4'b0000;
    wait_idle();
  endtask

  task automatic test_idle_led();
    int lit;
    int exp_lit;
    req = 4'b0000;
    repeat (20) @(negedge clk_in);
    lit = 0;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk_in);
      if (led_out === 1'b0) lit++;
    end
`ifdef LED_CODE_ARB_HEARTBEAT_EN
    exp_lit = 16;
`else
    exp_lit = 0;
`endif
    checks++;
    if (lit != exp_lit) begin
      errors++;
      $display("FAIL idle_led: lit %0d of 32 cycles, required %0d", lit, exp_lit);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    n_rst  = 1'b0;
    req    = 4'b0000;
    code   = 16'h0000;
    test_reset();
    test_code3();
    test_code0();
    test_round_robin();
    test_drop_and_code_change();
    test_async_reset();
    test_idle_led();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
